lc3b_mem_arbiter: RTL

- Arbitrates the single physical-memory port between the instruction-fetch side (I) and the data-access side (D) of the LC-3b pipeline.
- The D side is driven by the LDR/STR/LDB/STB control word.
- Each side uses the codebase's level read/write plus one-cycle resp handshake.
- On grant, the arbiter latches the request, drives it downstream, and routes the response back to the granted requester.

---
 rtl/lc3b_mem_arbiter_pkg.sv | 49 ++++
 rtl/arb_req_latch.sv | 46 ++++
 rtl/lc3b_mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared LC-3b memory-arbiter types: line/word typedefs, FSM and side enums,
// and the helpers that pick a grant side and resolve a request's operation.
package lc3b_mem_arbiter_pkg;

   localparam int LC3B_ADDR_W = 16;
   localparam int LC3B_LINE_W = 128;

   typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
   typedef logic [LC3B_LINE_W-1:0] lc3b_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } lc3b_arb_state;

   typedef enum logic {
      ARB_I = 1'b0,
      ARB_D = 1'b1
   } lc3b_arb_side;

   typedef struct packed {
      logic read;
      logic write;
   } lc3b_arb_op;

   // A tie goes to the side that was not granted last.
   function automatic lc3b_arb_side arb_pick(input logic         i_pend,
                                             input logic         d_pend,
                                             input lc3b_arb_side last);
      if (i_pend && d_pend) begin
         return (last == ARB_I) ? ARB_D : ARB_I;
      end else if (d_pend) begin
         return ARB_D;
      end else begin
         return ARB_I;
      end
   endfunction

   // A request carrying both read and write is treated as a write.
   function automatic lc3b_arb_op arb_op_resolve(input logic rd, input logic wr);
      lc3b_arb_op op;
      op.write = wr;
      op.read  = rd & ~wr;
      return op;
   endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Holds the granted request (operation, address, write data) for the whole
// downstream transaction so requester changes after grant have no effect.
module arb_req_latch
   import lc3b_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = LC3B_ADDR_W,
   parameter int LINE_W = LC3B_LINE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [LINE_W-1:0] i_wdata,
   output logic              o_read,
   output logic              o_write,
   output logic [ADDR_W-1:0] o_address,
   output logic [LINE_W-1:0] o_wdata
);

   logic              r_read;
   logic              r_write;
   logic [ADDR_W-1:0] r_address;
   logic [LINE_W-1:0] r_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_read    <= 1'b0;
         r_write   <= 1'b0;
         r_address <= '0;
         r_wdata   <= '0;
      end else if (i_load) begin
         r_read    <= i_read;
         r_write   <= i_write;
         r_address <= i_address;
         r_wdata   <= i_wdata;
      end
   end

   assign o_read    = r_read;
   assign o_write   = r_write;
   assign o_address = r_address;
   assign o_wdata   = r_wdata;

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Two-way arbiter sharing the physical-memory port between the I-fetch and
// D-access sides; one latched transaction at a time, response routed back.
module lc3b_mem_arbiter
   import lc3b_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = LC3B_ADDR_W,
   parameter int LINE_W = LC3B_LINE_W
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   lc3b_arb_state r_state;
   lc3b_arb_state w_state_nxt;
   lc3b_arb_side  r_last_grant;
   lc3b_arb_side  w_grant_side;

   logic              w_i_pend;
   logic              w_d_pend;
   logic              w_grant;
   logic              w_serving;

   logic              w_sel_read;
   logic              w_sel_write;
   logic [ADDR_W-1:0] w_sel_address;
   logic [LINE_W-1:0] w_sel_wdata;
   lc3b_arb_op        w_sel_op;

   logic              w_lat_read;
   logic              w_lat_write;
   logic [ADDR_W-1:0] w_lat_address;
   logic [LINE_W-1:0] w_lat_wdata;

   assign w_i_pend     = i_read | i_write;
   assign w_d_pend     = d_read | d_write;
   assign w_grant      = (r_state == IDLE) && (w_i_pend || w_d_pend);
   assign w_grant_side = arb_pick(w_i_pend, w_d_pend, r_last_grant);

   always_comb begin
      if (w_grant_side == ARB_D) begin
         w_sel_read    = d_read;
         w_sel_write   = d_write;
         w_sel_address = d_address;
         w_sel_wdata   = d_wdata;
      end else begin
         w_sel_read    = i_read;
         w_sel_write   = i_write;
         w_sel_address = i_address;
         w_sel_wdata   = i_wdata;
      end
   end

   assign w_sel_op = arb_op_resolve(w_sel_read, w_sel_write);

   arb_req_latch #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) u_req_latch (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_grant),
      .i_read    (w_sel_op.read),
      .i_write   (w_sel_op.write),
      .i_address (w_sel_address),
      .i_wdata   (w_sel_wdata),
      .o_read    (w_lat_read),
      .o_write   (w_lat_write),
      .o_address (w_lat_address),
      .o_wdata   (w_lat_wdata)
   );

   // DONE gives the served requester one cycle to drop its request.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_state_nxt = (w_grant_side == ARB_D) ? SERVE_D : SERVE_I;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= ARB_I;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_last_grant <= w_grant_side;
         end
      end
   end

   // Downstream strobes and responses are decoded from state so reset kills them at once.
   assign w_serving    = (r_state == SERVE_I) || (r_state == SERVE_D);
   assign pmem_read    = w_serving & w_lat_read;
   assign pmem_write   = w_serving & w_lat_write;
   assign pmem_address = w_lat_address;
   assign pmem_wdata   = w_lat_wdata;

   assign i_resp  = (r_state == SERVE_I) & pmem_resp;
   assign d_resp  = (r_state == SERVE_D) & pmem_resp;
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

endmodule
